// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use stalls, EX redirects and
// multi-cycle data-memory waits with timeout, driving the pipeline-register enables.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_use_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             ex_redirect_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

  state_e             state_q, state_d;
  logic               pend_redir_q, pend_redir_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic lu, redir, mwait;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;

  assign lu = idex_memread_i && (idex_rt_i != 5'd0) &&
              ((idex_rt_i == ifid_rs_i) || (ifid_use_rt_i && (idex_rt_i == ifid_rt_i)));
  assign redir = ex_redirect_i | pend_redir_q;
  assign mwait = dmem_req_i & ~dmem_ready_i;

  always_comb begin
    state_d      = state_q;
    pend_redir_d = pend_redir_q;
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = mem_err_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    pipe_freeze  = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mwait) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          pipe_freeze  = 1'b1;
          wait_cnt_d   = WaitW'(1);
          pend_redir_d = ex_redirect_i;
          // With a one-cycle budget the first waiting cycle is already the last.
          if (MEM_TIMEOUT <= 1) begin
            state_d   = StErr;
            mem_err_d = 1'b1;
          end else begin
            state_d = StMemWait;
          end
        end else if (redir) begin
          ifid_flush   = 1'b1;
          idex_bubble  = 1'b1;
          pend_redir_d = 1'b0;
        end else if (lu) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end

      StMemWait: begin
        if (dmem_ready_i) begin
          state_d      = StRun;
          wait_cnt_d   = '0;
          pend_redir_d = 1'b0;
          if (redir) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end else begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          pipe_freeze  = 1'b1;
          pend_redir_d = pend_redir_q | ex_redirect_i;
          // wait_cnt_q counts waiting cycles already completed, so this is the last allowed one.
          if (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1)) begin
            state_d   = StErr;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end
      end

      StErr: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        pipe_freeze = 1'b1;
      end

      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StRun;
      pend_redir_q <= 1'b0;
      wait_cnt_q   <= '0;
      mem_err_q    <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_redir_q <= pend_redir_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_err_q    <= mem_err_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Reset holds the pipeline frozen and bubbled regardless of the decoded state.
  assign pc_write_o    = rst_ni & pc_write;
  assign ifid_write_o  = rst_ni & ifid_write;
  assign ifid_flush_o  = rst_ni & ifid_flush;
  assign idex_bubble_o = ~rst_ni | idex_bubble;
  assign pipe_freeze_o = ~rst_ni | pipe_freeze;
  assign mem_err_o     = mem_err_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule
